// File: rtl/dff_bank_pkg.sv
// Shared types and sizing helpers for the DFF bank write arbiter.
package dff_bank_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StHold
  } state_e;

  localparam bit Q_RST = 1'b0;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned owner_w(input int unsigned nreq);
    return clog2_min1(nreq);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick
  import dff_bank_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned OwnerW = owner_w(NREQ)
) (
  input  logic [NREQ-1:0]   req_i,
  input  logic [OwnerW-1:0] ptr_i,
  output logic              any_o,
  output logic [OwnerW-1:0] winner_o
);

  logic [OwnerW-1:0] idx;

  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = OwnerW'((32'(ptr_i) + i) % NREQ);
      if (!any_o && req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter in front of a shared DFF storage word.
// Each access runs arbitrate -> one WRITE cycle -> HOLD_CYCLES settle cycles.
module dff_bank_arbiter
  import dff_bank_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*WIDTH-1:0]    wdata_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic                     done_o,
  output logic [owner_w(NREQ)-1:0] owner_o,
  output logic [WIDTH-1:0]         q_o,
  output logic                     busy_o
);

  localparam int unsigned OwnerW = owner_w(NREQ);
  localparam int unsigned CntW   = clog2_min1(HOLD_CYCLES);

  state_e            state_q;
  logic [NREQ-1:0]   gnt_q;
  logic              done_q;
  logic [OwnerW-1:0] owner_q, ptr_q, winner;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  q_q, wr_slice;
  logic              any_req, arb_en;

  rr_pick #(
    .NREQ  (NREQ),
    .OwnerW(OwnerW)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .any_o   (any_req),
    .winner_o(winner)
  );

  always_comb begin
    wr_slice = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == OwnerW'(i)) wr_slice = wdata_i[i*WIDTH +: WIDTH];
    end
  end

  // The last HOLD edge doubles as the next arbitration edge, so back-to-back
  // accesses are spaced exactly 1+HOLD_CYCLES cycles apart.
  assign arb_en = (state_q == StIdle) || ((state_q == StHold) && (cnt_q == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      q_q     <= {WIDTH{Q_RST}};
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StWrite: begin
          q_q     <= wr_slice;
          gnt_q   <= '0;
          done_q  <= 1'b1;
          cnt_q   <= CntW'(HOLD_CYCLES - 1);
          ptr_q   <= (owner_q == OwnerW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          state_q <= StHold;
        end
        StIdle, StHold: begin
          if (!arb_en) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (any_req) begin
            state_q <= StWrite;
            gnt_q   <= NREQ'(1) << winner;
            owner_q <= winner;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign owner_o = owner_q;
  assign q_o     = q_q;
  assign busy_o  = (state_q != StIdle);

endmodule
